i2s_tdm_clock_gen: RTL and testbench
====================================

# i2s_tdm_clock_gen

Parametrised I2S/TDM master clock generator. It derives BCLK and a frame-sync/LRCLK from a single fast clock, using a programmable divider and slot count. It supports four frame formats and exposes bit/slot position strobes so serialisers in the same clock domain can load and sample data without edge-detecting BCLK. It replaces the fixed 2×32-bit, BCLK/64 clock chain in the transceiver audio path and adds run/stop control and glitch-free rate changes.

## Interface
Parameters:
- SLOT_BITS, 32, bits per slot (power of 2, 8..32)
- SLOTS, 2, maximum slots per frame (2..16)
- DIV_W, 8, width of divider input

Ports:
- clk  in  1  fast master clock (SAICLK domain)
- reset  in  1  asynchronous, active-low
- enable  in  1  run request; level-sensitive
- div  in  DIV_W  BCLK half-period in clk cycles minus 1
- mode  in  2  0 = I2S, 1 = left-justified, 2 = DSP-A pulse, 3 = DSP-B pulse
- slots  in  clog2(SLOTS)+1  active slots per frame; values <2 are treated as 2, values >SLOTS are treated as SLOTS
- bclk  out  1  bit clock
- lrclk  out  1  LRCLK (modes 0/1) or frame-sync pulse (modes 2/3)
- bclk_rise  out  1  one-clk strobe, first clk cycle with bclk high
- bclk_fall  out  1  one-clk strobe, first clk cycle with bclk low
- frame_start  out  1  one-clk strobe when position becomes 0
- slot  out  max(1,clog2(SLOTS))  current slot index
- bit_idx  out  clog2(SLOT_BITS)  bit index within slot, 0 = MSB
- running  out  1  generator active

## Operation
- State machine:
  - IDLE: bclk=0, lrclk=0, counters 0, running=0.
  - RUN: active generation.
- IDLE→RUN: enable sampled high. On that edge the block latches div, mode and slots into shadow registers, sets position p=0 and pulses frame_start. It drives lrclk for p=0, loads the divider with div, and sets running=1.
- Divider: counts down from the shadow div. At 0 it toggles bclk and reloads. BCLK period = 2·(div+1) clk cycles; div=0 gives clk/2.
- BCLK starts low. Each bclk falling edge advances p = slot·SLOT_BITS + bit_idx, modulo N = slots·SLOT_BITS.
- lrclk and all position outputs change only together with a bclk fall. The first half-period after start is low.
- Let H = ceil(slots/2)·SLOT_BITS. lrclk value for position p:
  - mode 1: 1 when p < H, else 0.
  - mode 0: 1 when ((p+1) mod N) ≥ H. Left half is low, and lrclk changes one BCLK before the MSB.
  - mode 2: 1 only when p = N−1 (one-bit pulse preceding slot 0 MSB).
  - mode 3: 1 only when p = 0 (pulse coincident with slot 0 MSB).
- Frame wrap (p returns to 0):
  - If enable=1: re-latch div/mode/slots and pulse frame_start. The new div applies starting with the next half-period.
  - If enable=0: go to IDLE instead. There is no frame_start, bclk stays 0 and lrclk becomes 0 on the same edge.
- Config inputs changing mid-frame have no effect until the next frame wrap. No BCLK half-period differs from either the old or the new div.
- enable deasserted mid-frame: the current frame completes fully, so the bench never sees a partial frame. enable reasserted before wrap cancels the stop.

## Timing
- Reset values: bclk=0, lrclk=0, bclk_rise=0, bclk_fall=0, frame_start=0, slot=0, bit_idx=0, running=0.
- Reset is asynchronous and can occur mid-frame. On release the block starts in IDLE, and the first start happens on the first clk edge where enable=1.
- Start latency: running, frame_start and lrclk(p=0) are valid 1 clk after enable is sampled. The first bclk rise occurs div+1 clk later.
- bclk_rise and bclk_fall are registered together with bclk, so they are high in exactly the first clk cycle of each new bclk level. frame_start coincides with bclk_fall, or with the start cycle.
- slot, bit_idx and lrclk are stable from one bclk fall to the next. A consumer samples data on bclk_rise and drives it on bclk_fall.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, div=2, mode=0, slots=2, enable=1:
  - bclk period is 6 clk and lrclk period is 384 clk (64 BCLK).
  - lrclk falls at the bclk_fall of p=63, one BCLK before slot 0 MSB.
  - frame_start appears every 384 clk.
- mode=1, div=0:
  - bclk period is 2 clk.
  - lrclk is high exactly for p=0..31 and aligned with frame_start.
  - bclk_rise/bclk_fall alternate every clk.
- SLOTS=8, slots=8, mode=2, div=1:
  - Frame is 256 BCLK.
  - lrclk is high for exactly one BCLK (4 clk) at p=255.
  - slot counts 0..7 and bit_idx counts 0..31.
  - With mode=3 the pulse moves to p=0.
- div changed from 2 to 1 at p=20:
  - BCLK half-periods stay 3 clk until frame_start, then become 2 clk.
  - No half-period of any other length occurs.
- enable dropped at p=10:
  - Frame continues to p=63, then running=0, bclk=0, lrclk=0.
  - No extra frame_start.
  - Re-enable restarts at p=0 with the latency stated under Timing.
- reset asserted at p=40: all outputs reach their reset values immediately. After release with enable=1, the block restarts at p=0 within 1 clk.

Source files
------------

// File: rtl/i2s_tdm_clock_gen.sv
// I2S/TDM master clock generator: BCLK, LRCLK/frame-sync and bit/slot position strobes
// derived from one fast clock. Config is shadowed per frame so rate changes never glitch.
module i2s_tdm_clock_gen #(
  parameter int SLOT_BITS = 32,
  parameter int SLOTS     = 2,
  parameter int DIV_W     = 8,
  localparam int SLOTS_W    = $clog2(SLOTS) + 1,
  localparam int SLOT_IDX_W = ($clog2(SLOTS) > 1) ? $clog2(SLOTS) : 1,
  localparam int BIT_W      = $clog2(SLOT_BITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_W-1:0]      div,
  input  logic [1:0]            mode,
  input  logic [SLOTS_W-1:0]    slots,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  bclk_rise,
  output logic                  bclk_fall,
  output logic                  frame_start,
  output logic [SLOT_IDX_W-1:0] slot,
  output logic [BIT_W-1:0]      bit_idx,
  output logic                  running,
  output logic [0:0]            fsm_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int NW = SLOTS_W + BIT_W;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);

  logic [0:0]            state_q;
  logic [DIV_W-1:0]      div_cnt;
  logic [DIV_W-1:0]      sh_div;
  logic [1:0]            sh_mode;
  logic [SLOTS_W-1:0]    sh_slots;

  logic [SLOTS_W-1:0]    cfg_slots;
  logic [SLOTS_W-1:0]    slot_ext;
  logic                  bit_last;
  logic                  frame_last;
  logic [BIT_W-1:0]      nxt_bit;
  logic [SLOT_IDX_W-1:0] nxt_slot;
  logic                  lr_next;
  logic                  lr_start;

  function automatic logic [SLOTS_W-1:0] clamp_slots(input logic [SLOTS_W-1:0] s);
    if (s < SLOTS_W'(2))          return SLOTS_W'(2);
    else if (s > SLOTS_W'(SLOTS)) return SLOTS_W'(SLOTS);
    else                          return s;
  endfunction

  // lrclk level for position p of a frame of ns slots in format m
  function automatic logic lr_of(input logic [NW-1:0] p, input logic [1:0] m,
                                 input logic [SLOTS_W-1:0] ns);
    logic [NW-1:0]      n;
    logic [NW-1:0]      h;
    logic [NW-1:0]      p1;
    logic [SLOTS_W-1:0] hs;
    logic               lr;
    n  = {ns, {BIT_W{1'b0}}};
    hs = (ns + 1'b1) >> 1;
    h  = {hs, {BIT_W{1'b0}}};
    p1 = (p == n - 1'b1) ? '0 : p + 1'b1;
    case (m)
      2'd0:    lr = (p1 >= h);
      2'd1:    lr = (p < h);
      2'd2:    lr = (p == n - 1'b1);
      default: lr = (p == '0);
    endcase
    return lr;
  endfunction

  always_comb begin
    cfg_slots  = clamp_slots(slots);
    slot_ext   = SLOTS_W'(slot);
    bit_last   = (bit_idx == BIT_LAST);
    frame_last = bit_last && (slot_ext == sh_slots - 1'b1);
    nxt_bit    = bit_last ? '0 : bit_idx + 1'b1;
    nxt_slot   = bit_last ? slot + 1'b1 : slot;
    lr_next    = lr_of({1'b0, nxt_slot, nxt_bit}, sh_mode, sh_slots);
    lr_start   = lr_of('0, mode, cfg_slots);
  end

  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      div_cnt     <= '0;
      sh_div      <= '0;
      sh_mode     <= '0;
      sh_slots    <= SLOTS_W'(2);
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      bclk_rise   <= 1'b0;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      slot        <= '0;
      bit_idx     <= '0;
      running     <= 1'b0;
    end else begin
      bclk_rise   <= 1'b0;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q     <= RUN;
            running     <= 1'b1;
            sh_div      <= div;
            sh_mode     <= mode;
            sh_slots    <= cfg_slots;
            div_cnt     <= div;
            frame_start <= 1'b1;
            lrclk       <= lr_start;
            slot        <= '0;
            bit_idx     <= '0;
          end
        end
        default: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (!bclk) begin
            bclk      <= 1'b1;
            bclk_rise <= 1'b1;
            div_cnt   <= sh_div;
          end else begin
            bclk      <= 1'b0;
            bclk_fall <= 1'b1;
            if (frame_last) begin
              slot    <= '0;
              bit_idx <= '0;
              // Frame boundary is the only point where new config or a stop takes effect
              if (enable) begin
                sh_div      <= div;
                sh_mode     <= mode;
                sh_slots    <= cfg_slots;
                div_cnt     <= div;
                frame_start <= 1'b1;
                lrclk       <= lr_start;
              end else begin
                state_q <= IDLE;
                running <= 1'b0;
                lrclk   <= 1'b0;
                div_cnt <= '0;
              end
            end else begin
              slot    <= nxt_slot;
              bit_idx <= nxt_bit;
              lrclk   <= lr_next;
              div_cnt <= sh_div;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Directed bench for i2s_tdm_clock_gen (SLOTS=8, SLOT_BITS=32): frame formats, divider
// changes, stop/restart and asynchronous reset, checked with immediate assertions.
module tb_i2s_tdm_clock_gen;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] div;
  logic [1:0] mode;
  logic [3:0] slots;
  logic       bclk;
  logic       lrclk;
  logic       bclk_rise;
  logic       bclk_fall;
  logic       frame_start;
  logic [2:0] slot;
  logic [4:0] bit_idx;
  logic       running;
  logic [0:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;

  i2s_tdm_clock_gen #(.SLOT_BITS(32), .SLOTS(8), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .div(div), .mode(mode), .slots(slots),
    .bclk(bclk), .lrclk(lrclk), .bclk_rise(bclk_rise), .bclk_fall(bclk_fall),
    .frame_start(frame_start), .slot(slot), .bit_idx(bit_idx), .running(running),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // which: 0 = bclk_rise, 1 = bclk_fall, 2 = frame_start; n = clk cycles waited
  task automatic wait_sig(input int which, input int budget, output int n);
    logic s;
    n = 0;
    do begin
      tick();
      n++;
      case (which)
        0:       s = bclk_rise;
        1:       s = bclk_fall;
        default: s = frame_start;
      endcase
    end while (!s && n < budget);
  endtask

  function automatic logic lr_model(input int p, input int m, input int ns);
    int n_bits = ns * 32;
    int half   = ((ns + 1) / 2) * 32;
    case (m)
      0:       return (((p + 1) % n_bits) >= half);
      1:       return (p < half);
      2:       return (p == n_bits - 1);
      default: return (p == 0);
    endcase
  endfunction

  // Walks one frame from its first position; half = expected BCLK half-period in clk
  task automatic check_frame(input int half, input int m, input int ns, input int chg_at,
                             input int new_div, input int drop_at);
    int t;
    for (int p = 0; p < ns * 32; p++) begin
      chk("position", {24'd0, slot, bit_idx}, p);
      chk("lrclk", lrclk, lr_model(p, m, ns));
      chk("frame_start", frame_start, (p == 0));
      if (p == chg_at) div = new_div[7:0];
      if (p == drop_at) enable = 1'b0;
      wait_sig(0, 4 * half + 8, t);
      chk("bclk_low_len", t, half);
      wait_sig(1, 4 * half + 8, t);
      chk("bclk_high_len", t, half);
    end
    if (drop_at >= 0) begin
      chk("stop_running", running, 0);
      chk("stop_bclk", bclk, 0);
      chk("stop_lrclk", lrclk, 0);
      chk("stop_no_fs", frame_start, 0);
    end else begin
      chk("wrap_fs", frame_start, 1);
    end
  endtask

  initial begin
    int t;
    reset = 1'b0;
    enable = 1'b0;
    div = 8'd0;
    mode = 2'd0;
    slots = 4'd2;
    repeat (3) tick();
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_rise", bclk_rise, 0);
    chk("rst_fall", bclk_fall, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_slot", slot, 0);
    chk("rst_bit", bit_idx, 0);
    chk("rst_running", running, 0);
    #2 reset = 1'b1;
    tick();
    chk("idle_running", running, 0);

    // defaults: I2S, div=2, 2 slots
    div = 8'd2;
    enable = 1'b1;
    tick();
    chk("start_running", running, 1);
    chk("start_fs", frame_start, 1);
    chk("start_bclk", bclk, 0);
    chk("start_lrclk", lrclk, 0);
    check_frame(3, 0, 2, -1, 0, -1);
    wait_sig(2, 1000, t);
    chk("i2s_frame_len", t, 384);
    repeat (62) wait_sig(1, 20, t);
    chk("i2s_lr_p62", lrclk, 1);
    wait_sig(1, 20, t);
    chk("i2s_lr_p63", lrclk, 0);
    chk("i2s_slot_p63", slot, 1);
    chk("i2s_bit_p63", bit_idx, 31);
    wait_sig(1, 20, t);
    chk("i2s_fs_after_p63", frame_start, 1);

    // left-justified, div=0; change mid-frame waits for the wrap
    mode = 2'd1;
    div = 8'd0;
    wait_sig(2, 1000, t);
    chk("lj_old_frame_len", t, 384);
    check_frame(1, 1, 2, -1, 0, -1);

    // 8-slot DSP-A then DSP-B at div=1
    slots = 4'd8;
    mode = 2'd2;
    div = 8'd1;
    wait_sig(2, 1000, t);
    chk("lj_frame_len", t, 128);
    check_frame(2, 2, 8, -1, 0, -1);
    mode = 2'd3;
    wait_sig(2, 2000, t);
    chk("dspa_frame_len", t, 1024);
    check_frame(2, 3, 8, -1, 0, -1);

    // slot count clamping: 0 acts as 2, 15 acts as 8
    slots = 4'd0;
    mode = 2'd1;
    div = 8'd0;
    wait_sig(2, 2000, t);
    chk("dspb_frame_len", t, 1024);
    check_frame(1, 1, 2, -1, 0, -1);
    slots = 4'd15;
    wait_sig(2, 1000, t);
    chk("clamp_lo_frame_len", t, 128);
    check_frame(1, 1, 8, -1, 0, -1);

    // divider change 2 -> 1 at p=20, then enable dropped at p=10
    slots = 4'd2;
    mode = 2'd0;
    div = 8'd2;
    wait_sig(2, 1000, t);
    chk("clamp_hi_frame_len", t, 512);
    check_frame(3, 0, 2, 20, 1, -1);
    check_frame(2, 0, 2, -1, 0, 10);
    wait_sig(2, 50, t);
    chk("idle_no_fs", t, 50);
    chk("idle_bclk", bclk, 0);
    enable = 1'b1;
    tick();
    chk("restart_running", running, 1);
    chk("restart_fs", frame_start, 1);
    check_frame(2, 0, 2, -1, 0, -1);

    // asynchronous reset at p=40
    repeat (40) wait_sig(1, 20, t);
    chk("pre_reset_pos", {24'd0, slot, bit_idx}, 40);
    reset = 1'b0;
    #1;
    chk("mid_rst_bclk", bclk, 0);
    chk("mid_rst_lrclk", lrclk, 0);
    chk("mid_rst_rise", bclk_rise, 0);
    chk("mid_rst_fall", bclk_fall, 0);
    chk("mid_rst_fs", frame_start, 0);
    chk("mid_rst_pos", {24'd0, slot, bit_idx}, 0);
    chk("mid_rst_running", running, 0);
    #2 reset = 1'b1;
    tick();
    chk("post_rst_running", running, 1);
    chk("post_rst_fs", frame_start, 1);
    check_frame(2, 0, 2, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
